// File: rtl/vga_raster_gen.sv
// rtl/vga_raster_gen.sv - VGA raster/timing generator with latency-aligned registered DAC outputs
// Optional colour-bar source enabled by `define VGA_RASTER_TEST_PATTERN_EN (adds tp_sel input).
module vga_raster_gen #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic HS_POL      = 1'b0,
  parameter logic VS_POL      = 1'b0,
  parameter int   PIX_LATENCY = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
`ifdef VGA_RASTER_TEST_PATTERN_EN
  input  logic        tp_sel,
`endif
  output logic [12:0] row,
  output logic [12:0] col,
  input  logic [7:0]  pix_R,
  input  logic [7:0]  pix_G,
  input  logic [7:0]  pix_B,
  output logic [7:0]  o_VGA_R,
  output logic [7:0]  o_VGA_G,
  output logic [7:0]  o_VGA_B,
  output logic        o_VGA_HS,
  output logic        o_VGA_VS,
  output logic        o_VGA_BLANK_N,
  output logic        o_VGA_SYNC_N,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [12:0] H_LAST   = 13'(H_TOTAL - 1);
  localparam logic [12:0] V_LAST   = 13'(V_TOTAL - 1);
  localparam logic [12:0] H_ACT    = 13'(H_ACTIVE);
  localparam logic [12:0] V_ACT    = 13'(V_ACTIVE);
  localparam logic [12:0] H_SYNC_S = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_SYNC_E = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_SYNC_S = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_SYNC_E = 13'(V_ACTIVE + V_FP + V_SYNC);

`ifdef VGA_RASTER_TEST_PATTERN_EN
  localparam int FW = 7;
  localparam logic [12:0] BAR_W = 13'(H_ACTIVE / 8);
`else
  localparam int FW = 4;
`endif

  logic [12:0] h_cnt_q, h_cnt_d;
  logic [12:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 13'd0 : v_cnt_q + 13'd1;
      end else begin
        h_cnt_d = h_cnt_q + 13'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign row = v_cnt_q;
  assign col = h_cnt_q;

  logic active_raw, hs_raw, vs_raw, first_raw;
  assign active_raw = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs_raw     = (h_cnt_q >= H_SYNC_S) && (h_cnt_q < H_SYNC_E);
  assign vs_raw     = (v_cnt_q >= V_SYNC_S) && (v_cnt_q < V_SYNC_E);
  assign first_raw  = (h_cnt_q == 13'd0) && (v_cnt_q == 13'd0);

  logic [FW-1:0] fl_cur, fl_dly;
`ifdef VGA_RASTER_TEST_PATTERN_EN
  // Bar index rides the same delay line so the bars line up with live pixels.
  logic [2:0] bar_raw;
  assign bar_raw = 3'(h_cnt_q / BAR_W);
  assign fl_cur  = {bar_raw, first_raw, vs_raw, hs_raw, active_raw};
`else
  assign fl_cur  = {first_raw, vs_raw, hs_raw, active_raw};
`endif

  generate
    if (PIX_LATENCY == 0) begin : g_nodly
      assign fl_dly = fl_cur;
    end else begin : g_dly
      // Cleared to all-zero so reset bubbles emerge as black with idle syncs.
      logic [FW-1:0] sr_q [PIX_LATENCY];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < PIX_LATENCY; i++) sr_q[i] <= '0;
        end else if (pix_en) begin
          sr_q[0] <= fl_cur;
          for (int i = 1; i < PIX_LATENCY; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign fl_dly = sr_q[PIX_LATENCY-1];
    end
  endgenerate

  logic active_d, hs_dly, vs_dly, first_d;
  assign active_d = fl_dly[0];
  assign hs_dly   = fl_dly[1];
  assign vs_dly   = fl_dly[2];
  assign first_d  = fl_dly[3];

  logic [7:0] r_d, g_d, b_d;
  logic       hs_d, vs_d;

  always_comb begin
    r_d = 8'h00;
    g_d = 8'h00;
    b_d = 8'h00;
    if (active_d) begin
`ifdef VGA_RASTER_TEST_PATTERN_EN
      if (tp_sel) begin
        r_d = {8{fl_dly[6]}};
        g_d = {8{fl_dly[5]}};
        b_d = {8{fl_dly[4]}};
      end else
`endif
      begin
        r_d = pix_R;
        g_d = pix_G;
        b_d = pix_B;
      end
    end
    hs_d = hs_dly ? HS_POL : ~HS_POL;
    vs_d = vs_dly ? VS_POL : ~VS_POL;
  end

  logic [7:0] r_q, g_q, b_q;
  logic       hs_q, vs_q, blank_n_q, sync_n_q, frame_start_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q           <= 8'h00;
      g_q           <= 8'h00;
      b_q           <= 8'h00;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_n_q     <= 1'b0;
      sync_n_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pix_en) begin
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_n_q     <= active_d;
      sync_n_q      <= 1'b0;
      frame_start_q <= first_d;
    end
  end

  assign o_VGA_R       = r_q;
  assign o_VGA_G       = g_q;
  assign o_VGA_B       = b_q;
  assign o_VGA_HS      = hs_q;
  assign o_VGA_VS      = vs_q;
  assign o_VGA_BLANK_N = blank_n_q;
  assign o_VGA_SYNC_N  = sync_n_q;
  assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_raster_gen.sv
// tb/tb_vga_raster_gen.sv - directed self-checking bench for vga_raster_gen
// Instance A: 16x6 raster (24x10 totals), latency 0. Instance B: default 640x480 timing, latency 3.
module tb_vga_raster_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, pix_en;
  logic [7:0]  pix_R_a, pix_G_a, pix_B_a, pix_R_b, pix_G_b, pix_B_b;
  logic [12:0] row_a, col_a, row_b, col_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        hs_a, vs_a, bn_a, sn_a, fs_a;
  logic        hs_b, vs_b, bn_b, sn_b, fs_b;
`ifdef VGA_RASTER_TEST_PATTERN_EN
  logic        tp_sel = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int n_en   = 0;

  vga_raster_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIX_LATENCY(0)
  ) u_dut_a (
    .clk(clk), .reset(reset), .pix_en(pix_en),
`ifdef VGA_RASTER_TEST_PATTERN_EN
    .tp_sel(tp_sel),
`endif
    .row(row_a), .col(col_a),
    .pix_R(pix_R_a), .pix_G(pix_G_a), .pix_B(pix_B_a),
    .o_VGA_R(r_a), .o_VGA_G(g_a), .o_VGA_B(b_a),
    .o_VGA_HS(hs_a), .o_VGA_VS(vs_a), .o_VGA_BLANK_N(bn_a),
    .o_VGA_SYNC_N(sn_a), .frame_start(fs_a)
  );

  vga_raster_gen #(
    .PIX_LATENCY(3)
  ) u_dut_b (
    .clk(clk), .reset(reset), .pix_en(pix_en),
`ifdef VGA_RASTER_TEST_PATTERN_EN
    .tp_sel(tp_sel),
`endif
    .row(row_b), .col(col_b),
    .pix_R(pix_R_b), .pix_G(pix_G_b), .pix_B(pix_B_b),
    .o_VGA_R(r_b), .o_VGA_G(g_b), .o_VGA_B(b_b),
    .o_VGA_HS(hs_b), .o_VGA_VS(vs_b), .o_VGA_BLANK_N(bn_b),
    .o_VGA_SYNC_N(sn_b), .frame_start(fs_b)
  );

  // Raster position after n enabled clocks, for each instance.
  function automatic int ah(input int n); return n % 24; endfunction
  function automatic int av(input int n); return (n / 24) % 10; endfunction
  function automatic int bh(input int n); return n % 800; endfunction
  function automatic int bv(input int n); return (n / 800) % 525; endfunction

  // Stand-in process stage for instance A: a colour unique-ish per coordinate.
  function automatic logic [7:0] ar(input int n); return 8'((ah(n) * 7 + av(n) * 3 + 1) & 255); endfunction
  function automatic logic [7:0] ag(input int n); return 8'(240 - ah(n)); endfunction
  function automatic logic [7:0] ab(input int n); return 8'(av(n) * 16 + 15); endfunction

  task automatic tick(input logic en);
    pix_en  = en;
    pix_R_a = ar(n_en);
    pix_G_a = ag(n_en);
    pix_B_a = ab(n_en);
    pix_R_b = (n_en >= 3) ? 8'(bh(n_en - 3)) : 8'hA5;
    pix_G_b = 8'h11;
    pix_B_b = 8'h22;
    @(posedge clk);
    if (en) n_en++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset  = 1'b1;
    pix_en = 1'b0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    n_en   = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_en = 1'b1;
    pix_R_a = 8'hFF; pix_G_a = 8'hFF; pix_B_a = 8'hFF;
    pix_R_b = 8'hFF; pix_G_b = 8'hFF; pix_B_b = 8'hFF;
    repeat (3) @(negedge clk);
    checks++; if (row_a !== 13'd0) begin errors++; $display("FAIL reset_row_a: got %0d expected 0", row_a); end
    checks++; if (col_a !== 13'd0) begin errors++; $display("FAIL reset_col_a: got %0d expected 0", col_a); end
    checks++; if (r_a !== 8'h00) begin errors++; $display("FAIL reset_r_a: got %0h expected 0", r_a); end
    checks++; if (g_a !== 8'h00) begin errors++; $display("FAIL reset_g_a: got %0h expected 0", g_a); end
    checks++; if (b_a !== 8'h00) begin errors++; $display("FAIL reset_b_a: got %0h expected 0", b_a); end
    checks++; if (bn_a !== 1'b0) begin errors++; $display("FAIL reset_blank_a: got %0b expected 0", bn_a); end
    checks++; if (sn_a !== 1'b0) begin errors++; $display("FAIL reset_sync_n_a: got %0b expected 0", sn_a); end
    checks++; if (hs_a !== 1'b1) begin errors++; $display("FAIL reset_hs_a: got %0b expected 1", hs_a); end
    checks++; if (vs_a !== 1'b1) begin errors++; $display("FAIL reset_vs_a: got %0b expected 1", vs_a); end
    checks++; if (fs_a !== 1'b0) begin errors++; $display("FAIL reset_fs_a: got %0b expected 0", fs_a); end
    checks++; if (r_b !== 8'h00) begin errors++; $display("FAIL reset_r_b: got %0h expected 0", r_b); end
    checks++; if (hs_b !== 1'b1) begin errors++; $display("FAIL reset_hs_b: got %0b expected 1", hs_b); end
    checks++; if (vs_b !== 1'b1) begin errors++; $display("FAIL reset_vs_b: got %0b expected 1", vs_b); end
    checks++; if (col_b !== 13'd0) begin errors++; $display("FAIL reset_col_b: got %0d expected 0", col_b); end
    reset = 1'b0;
    n_en  = 0;
  endtask

  task automatic test_raster();
    int m, blanks, hsl, vsl, fss;
    logic act, ehs, evs, efs;
    blanks = 0; hsl = 0; vsl = 0; fss = 0;
    for (int i = 0; i < 480; i++) begin
      tick(1'b1);
      m   = n_en - 1;
      act = (ah(m) < 16) && (av(m) < 6);
      ehs = !((ah(m) >= 18) && (ah(m) < 21));
      evs = !((av(m) >= 7) && (av(m) < 9));
      efs = (m % 240) == 0;
      checks++; if (col_a !== 13'(ah(n_en))) begin errors++; $display("FAIL raster_col n=%0d: got %0d expected %0d", n_en, col_a, ah(n_en)); end
      checks++; if (row_a !== 13'(av(n_en))) begin errors++; $display("FAIL raster_row n=%0d: got %0d expected %0d", n_en, row_a, av(n_en)); end
      checks++; if (bn_a !== act) begin errors++; $display("FAIL raster_blank n=%0d: got %0b expected %0b", n_en, bn_a, act); end
      checks++; if (hs_a !== ehs) begin errors++; $display("FAIL raster_hs n=%0d: got %0b expected %0b", n_en, hs_a, ehs); end
      checks++; if (vs_a !== evs) begin errors++; $display("FAIL raster_vs n=%0d: got %0b expected %0b", n_en, vs_a, evs); end
      checks++; if (fs_a !== efs) begin errors++; $display("FAIL raster_fs n=%0d: got %0b expected %0b", n_en, fs_a, efs); end
      checks++; if (r_a !== (act ? ar(m) : 8'h00)) begin errors++; $display("FAIL raster_r n=%0d: got %0h expected %0h", n_en, r_a, act ? ar(m) : 8'h00); end
      checks++; if (g_a !== (act ? ag(m) : 8'h00)) begin errors++; $display("FAIL raster_g n=%0d: got %0h expected %0h", n_en, g_a, act ? ag(m) : 8'h00); end
      checks++; if (b_a !== (act ? ab(m) : 8'h00)) begin errors++; $display("FAIL raster_b n=%0d: got %0h expected %0h", n_en, b_a, act ? ab(m) : 8'h00); end
      if (bn_a === 1'b1) blanks++;
      if (hs_a === 1'b0) hsl++;
      if (vs_a === 1'b0) vsl++;
      if (fs_a === 1'b1) fss++;
    end
    checks++; if (blanks != 192) begin errors++; $display("FAIL raster_blank_count: got %0d expected 192", blanks); end
    checks++; if (hsl != 60) begin errors++; $display("FAIL raster_hs_count: got %0d expected 60", hsl); end
    checks++; if (vsl != 96) begin errors++; $display("FAIL raster_vs_count: got %0d expected 96", vsl); end
    checks++; if (fss != 2) begin errors++; $display("FAIL raster_fs_count: got %0d expected 2", fss); end
  endtask

  task automatic test_latency();
    int m, blanks, hsl;
    logic act, ehs, efs;
    blanks = 0; hsl = 0;
    apply_reset();
    for (int i = 0; i < 1603; i++) begin
      tick(1'b1);
      m   = n_en - 4;
      act = (m >= 0) && (bh(m) < 640) && (bv(m) < 480);
      ehs = !((m >= 0) && (bh(m) >= 656) && (bh(m) < 752));
      efs = (m == 0);
      checks++; if (col_b !== 13'(bh(n_en))) begin errors++; $display("FAIL lat_col n=%0d: got %0d expected %0d", n_en, col_b, bh(n_en)); end
      checks++; if (bn_b !== act) begin errors++; $display("FAIL lat_blank n=%0d: got %0b expected %0b", n_en, bn_b, act); end
      checks++; if (r_b !== (act ? 8'(bh(m)) : 8'h00)) begin errors++; $display("FAIL lat_r n=%0d: got %0h expected %0h", n_en, r_b, act ? 8'(bh(m)) : 8'h00); end
      checks++; if (g_b !== (act ? 8'h11 : 8'h00)) begin errors++; $display("FAIL lat_g n=%0d: got %0h", n_en, g_b); end
      checks++; if (hs_b !== ehs) begin errors++; $display("FAIL lat_hs n=%0d: got %0b expected %0b", n_en, hs_b, ehs); end
      checks++; if (vs_b !== 1'b1) begin errors++; $display("FAIL lat_vs n=%0d: got %0b expected 1", n_en, vs_b); end
      checks++; if (fs_b !== efs) begin errors++; $display("FAIL lat_fs n=%0d: got %0b expected %0b", n_en, fs_b, efs); end
      if (bn_b === 1'b1) blanks++;
      if (hs_b === 1'b0) hsl++;
    end
    checks++; if (row_b !== 13'd2) begin errors++; $display("FAIL lat_row_end: got %0d expected 2", row_b); end
    checks++; if (blanks != 1280) begin errors++; $display("FAIL lat_blank_count: got %0d expected 1280", blanks); end
    checks++; if (hsl != 192) begin errors++; $display("FAIL lat_hs_count: got %0d expected 192", hsl); end
  endtask

  task automatic test_pix_en_toggle();
    int m, rises, rise1, rise2;
    logic act, ehs, fs_prev;
    rises = 0; rise1 = -1; rise2 = -1; fs_prev = 1'b0;
    apply_reset();
    for (int i = 0; i < 960; i++) begin
      tick((i % 2) == 0);
      m   = n_en - 1;
      act = (ah(m) < 16) && (av(m) < 6);
      ehs = !((ah(m) >= 18) && (ah(m) < 21));
      checks++; if (col_a !== 13'(ah(n_en))) begin errors++; $display("FAIL toggle_col i=%0d: got %0d expected %0d", i, col_a, ah(n_en)); end
      checks++; if (row_a !== 13'(av(n_en))) begin errors++; $display("FAIL toggle_row i=%0d: got %0d expected %0d", i, row_a, av(n_en)); end
      checks++; if (bn_a !== act) begin errors++; $display("FAIL toggle_blank i=%0d: got %0b expected %0b", i, bn_a, act); end
      checks++; if (r_a !== (act ? ar(m) : 8'h00)) begin errors++; $display("FAIL toggle_r i=%0d: got %0h expected %0h", i, r_a, act ? ar(m) : 8'h00); end
      checks++; if (hs_a !== ehs) begin errors++; $display("FAIL toggle_hs i=%0d: got %0b expected %0b", i, hs_a, ehs); end
      if (fs_a === 1'b1 && fs_prev === 1'b0) begin
        rises++;
        if (rise1 < 0) rise1 = i; else if (rise2 < 0) rise2 = i;
      end
      fs_prev = fs_a;
    end
    checks++; if (rises != 2) begin errors++; $display("FAIL toggle_fs_rises: got %0d expected 2", rises); end
    checks++; if (rise2 - rise1 != 480) begin errors++; $display("FAIL toggle_frame_len: got %0d expected 480", rise2 - rise1); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (91) tick(1'b1);
    checks++; if (hs_a !== 1'b0) begin errors++; $display("FAIL async_pre_hs_a: got %0b expected 0", hs_a); end
    checks++; if (bn_b !== 1'b1) begin errors++; $display("FAIL async_pre_blank_b: got %0b expected 1", bn_b); end
    checks++; if (r_b !== 8'h57) begin errors++; $display("FAIL async_pre_r_b: got %0h expected 57", r_b); end
    #2 reset = 1'b1;
    #1;
    checks++; if (row_a !== 13'd0) begin errors++; $display("FAIL async_row_a: got %0d expected 0", row_a); end
    checks++; if (col_a !== 13'd0) begin errors++; $display("FAIL async_col_a: got %0d expected 0", col_a); end
    checks++; if (hs_a !== 1'b1) begin errors++; $display("FAIL async_hs_a: got %0b expected 1", hs_a); end
    checks++; if (vs_a !== 1'b1) begin errors++; $display("FAIL async_vs_a: got %0b expected 1", vs_a); end
    checks++; if (bn_b !== 1'b0) begin errors++; $display("FAIL async_blank_b: got %0b expected 0", bn_b); end
    checks++; if (r_b !== 8'h00) begin errors++; $display("FAIL async_r_b: got %0h expected 0", r_b); end
    checks++; if (col_b !== 13'd0) begin errors++; $display("FAIL async_col_b: got %0d expected 0", col_b); end
    @(negedge clk);
    reset = 1'b0;
    n_en  = 0;
    tick(1'b1);
    checks++; if (col_a !== 13'd1 || row_a !== 13'd0) begin errors++; $display("FAIL async_restart_pos: got %0d/%0d expected 0/1", row_a, col_a); end
    checks++; if (bn_a !== 1'b1) begin errors++; $display("FAIL async_restart_blank: got %0b expected 1", bn_a); end
    checks++; if (r_a !== 8'h01) begin errors++; $display("FAIL async_restart_r: got %0h expected 01", r_a); end
    checks++; if (fs_a !== 1'b1) begin errors++; $display("FAIL async_restart_fs: got %0b expected 1", fs_a); end
  endtask

`ifdef VGA_RASTER_TEST_PATTERN_EN
  task automatic test_test_pattern();
    int m, k;
    logic act;
    logic [7:0] er, eg, eb;
    tp_sel = 1'b1;
    apply_reset();
    for (int i = 0; i < 700; i++) begin
      tick(1'b1);
      m = n_en - 4;
      if (m >= 0) begin
        act = bh(m) < 640;
        k   = bh(m) / 80;
        er  = (act && (k & 4) != 0) ? 8'hFF : 8'h00;
        eg  = (act && (k & 2) != 0) ? 8'hFF : 8'h00;
        eb  = (act && (k & 1) != 0) ? 8'hFF : 8'h00;
        checks++; if (r_b !== er) begin errors++; $display("FAIL tp_r col=%0d: got %0h expected %0h", bh(m), r_b, er); end
        checks++; if (g_b !== eg) begin errors++; $display("FAIL tp_g col=%0d: got %0h expected %0h", bh(m), g_b, eg); end
        checks++; if (b_b !== eb) begin errors++; $display("FAIL tp_b col=%0d: got %0h expected %0h", bh(m), b_b, eb); end
      end
    end
    tp_sel = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; pix_en = 1'b0;
    pix_R_a = 8'h00; pix_G_a = 8'h00; pix_B_a = 8'h00;
    pix_R_b = 8'h00; pix_G_b = 8'h00; pix_B_b = 8'h00;
    test_reset();
    test_raster();
    test_latency();
    test_pix_en_toggle();
    test_async_reset();
`ifdef VGA_RASTER_TEST_PATTERN_EN
    test_test_pattern();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
